// File: rtl/nrdiv_pkg.sv
// Shared types and constants for the non-restoring divider.
// Optional signed mode is enabled by defining NRDIV_SIGNED_EN.
package nrdiv_pkg;

  localparam int NRDIV_WIDTH_DEFAULT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    ITER,
    FIX,
    DONE,
    SIGN
  } state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/nrdiv_step.sv
// One non-restoring step: shift {A,Q} left, then add or subtract M by A's old sign.
// With shift_i low it performs the final remainder correction (add M if A < 0).
module nrdiv_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH:0]   m_i,
  input  logic             shift_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    a_sh = a_i;
    q_sh = q_i;
    a_o  = a_i;
    q_o  = q_i;
    if (shift_i) begin
      a_sh = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
      q_sh = {q_i[WIDTH-2:0], 1'b0};
    end
    if (a_i[WIDTH]) begin
      a_o = a_sh + m_i;
    end else if (shift_i) begin
      a_o = a_sh - m_i;
    end else begin
      a_o = a_sh;
    end
    q_o = shift_i ? {q_sh[WIDTH-1:1], ~a_o[WIDTH]} : q_sh;
  end

endmodule

// File: rtl/nonrestoring_div_hs.sv
// Iterative non-restoring divider with valid/ready handshake and divide-by-zero flag.
// Define NRDIV_SIGNED_EN for two's-complement operands (adds one SIGN cycle).
module nonrestoring_div_hs
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = NRDIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH:0]   a_q;
  logic [WIDTH:0]   m_q;
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             div_by_zero_q;
  logic [WIDTH:0]   step_a;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] zero_rem;
`ifdef NRDIV_SIGNED_EN
  logic             neg_quo_q;
  logic             neg_rem_q;
`endif

  nrdiv_step #(.WIDTH(WIDTH)) u_step (
    .a_i    (a_q),
    .q_i    (q_q),
    .m_i    (m_q),
    .shift_i(state_q == ITER),
    .a_o    (step_a),
    .q_o    (step_q)
  );

`ifdef NRDIV_SIGNED_EN
  assign zero_rem = neg_rem_q ? -q_q : q_q;
`else
  assign zero_rem = q_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      a_q           <= '0;
      m_q           <= '0;
      q_q           <= '0;
      cnt_q         <= '0;
      zero_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
`ifdef NRDIV_SIGNED_EN
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            a_q        <= '0;
            cnt_q      <= CNT_W'(WIDTH);
            zero_q     <= (divisor == '0);
`ifdef NRDIV_SIGNED_EN
            q_q        <= dividend[WIDTH-1] ? -dividend : dividend;
            m_q        <= {1'b0, (divisor[WIDTH-1] ? -divisor : divisor)};
            neg_quo_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_q  <= dividend[WIDTH-1];
`else
            q_q        <= dividend;
            m_q        <= {1'b0, divisor};
`endif
            // A zero divisor skips the iterations but still takes the FIX cycle.
            state_q    <= (divisor == '0) ? FIX : ITER;
          end
        end
        ITER: begin
          a_q   <= step_a;
          q_q   <= step_q;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          if (zero_q) begin
            quotient_q    <= '1;
            remainder_q   <= zero_rem;
            div_by_zero_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state_q       <= DONE;
          end else begin
            quotient_q    <= q_q;
            remainder_q   <= step_a[WIDTH-1:0];
            div_by_zero_q <= 1'b0;
`ifdef NRDIV_SIGNED_EN
            state_q       <= SIGN;
`else
            out_valid_q   <= 1'b1;
            state_q       <= DONE;
`endif
          end
        end
`ifdef NRDIV_SIGNED_EN
        SIGN: begin
          if (neg_quo_q) quotient_q <= -quotient_q;
          if (neg_rem_q) remainder_q <= -remainder_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_nonrestoring_div_hs.sv
// Bench for nonrestoring_div_hs: an 8-bit and a 1024-bit instance checked against a scoreboard.
// Expectations follow NRDIV_SIGNED_EN when it is defined.
module tb_nonrestoring_div_hs;

  localparam int WS = 8;
  localparam int WL = 1024;
`ifdef NRDIV_SIGNED_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct {
    logic [WL-1:0] q;
    logic [WL-1:0] r;
    logic          z;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    in_valid;
  logic [1:0]    out_ready;
  logic [1:0]    in_ready;
  logic [1:0]    out_valid;
  logic [1:0]    dbz;
  logic [WS-1:0] dvd_s, dvs_s, quo_s, rem_s;
  logic [WL-1:0] dvd_l, dvs_l, quo_l, rem_l;

  int   cyc = 0;
  int   acc_cyc;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb_s[$];
  exp_t sb_l[$];

  always @(posedge clk) cyc <= cyc + 1;

  nonrestoring_div_hs #(.WIDTH(WS)) u_dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .dividend(dvd_s), .divisor(dvs_s),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .quotient(quo_s), .remainder(rem_s), .div_by_zero(dbz[0])
  );

  nonrestoring_div_hs #(.WIDTH(WL)) u_dut_l (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .dividend(dvd_l), .divisor(dvs_l),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .quotient(quo_l), .remainder(rem_l), .div_by_zero(dbz[1])
  );

  function automatic logic [WL-1:0] obs_q(input int u);
    return (u != 0) ? quo_l : WL'(quo_s);
  endfunction

  function automatic logic [WL-1:0] obs_r(input int u);
    return (u != 0) ? rem_l : WL'(rem_s);
  endfunction

  function automatic logic [WL-1:0] rand_w();
    logic [WL-1:0] v;
    for (int i = 0; i < WL / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: divide magnitudes with the simulator's own / and %, then fix signs.
  function automatic void model(input logic [WL-1:0] n_in, input logic [WL-1:0] d_in, input int w,
                                output logic [WL-1:0] q, output logic [WL-1:0] r, output logic z);
    logic [WL-1:0] mask, n, d, nm, dm;
    logic sn, sd;
    mask = (WL'(1) << w) - WL'(1);
    n = n_in & mask;
    d = d_in & mask;
    z = (d == '0);
`ifdef NRDIV_SIGNED_EN
    sn = n[w-1];
    sd = d[w-1];
`else
    sn = 1'b0;
    sd = 1'b0;
`endif
    nm = sn ? ((-n) & mask) : n;
    dm = sd ? ((-d) & mask) : d;
    if (z) begin
      q = mask;
      r = n;
    end else begin
      q = nm / dm;
      r = nm % dm;
      if (sn ^ sd) q = (-q) & mask;
      if (sn) r = (-r) & mask;
    end
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
    check({tag, "_hi"}, obs[WL-1:512], exp[WL-1:512]);
    check({tag, "_lo"}, obs[511:0], exp[511:0]);
  endtask

  task automatic send(input int u, input logic [WL-1:0] n, input logic [WL-1:0] d);
    exp_t e;
    int   g;
    model(n, d, (u != 0) ? WL : WS, e.q, e.r, e.z);
    e.lat = e.z ? 1 : ((u != 0) ? WL : WS) + 1 + EXTRA;
    @(negedge clk);
    if (u != 0) begin dvd_l = n; dvs_l = d; end
    else begin dvd_s = n[WS-1:0]; dvs_s = d[WS-1:0]; end
    in_valid[u] = 1'b1;
    g = 0;
    while (!in_ready[u] && g < 5000) begin @(negedge clk); g++; end
    check("accept_ready", 512'(in_ready[u]), 512'(1));
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid[u] = 1'b0;
    if (u != 0) begin dvd_l = ~n; dvs_l = rand_w(); end
    else begin dvd_s = WS'($urandom); dvs_s = WS'($urandom); end
    if (u != 0) sb_l.push_back(e); else sb_s.push_back(e);
    check("busy_after_accept", 512'(in_ready[u]), 512'(0));
  endtask

  task automatic receive(input int u, input int hold);
    exp_t e;
    int   edges;
    out_ready[u] = (hold == 0);
    edges = 0;
    while (!out_valid[u] && edges < 3000) begin @(posedge clk); #1; edges++; end
    check("out_valid_seen", 512'(out_valid[u]), 512'(1));
    if (u != 0) begin
      if (sb_l.size() == 0) return;
      e = sb_l.pop_front();
    end else begin
      if (sb_s.size() == 0) return;
      e = sb_s.pop_front();
    end
    check("latency_edges", 512'(edges), 512'(e.lat));
    check_w("quotient", obs_q(u), e.q);
    check_w("remainder", obs_r(u), e.r);
    check("div_by_zero", 512'(dbz[u]), 512'(e.z));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 512'(out_valid[u]), 512'(1));
      check("hold_busy", 512'(in_ready[u]), 512'(0));
      check_w("hold_quotient", obs_q(u), e.q);
      check_w("hold_remainder", obs_r(u), e.r);
    end
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[u] = 1'b0;
    check("valid_drop", 512'(out_valid[u]), 512'(0));
    check("ready_back", 512'(in_ready[u]), 512'(1));
  endtask

  initial begin
    logic [WL-1:0] n, d;
    int            prev_acc;

    in_valid  = '0;
    out_ready = '0;
    dvd_s = '0; dvs_s = '0; dvd_l = '0; dvs_l = '0;
    rst = 1'b1;
    #12;
    for (int u = 0; u < 2; u++) begin
      check("rst_in_ready", 512'(in_ready[u]), 512'(1));
      check("rst_out_valid", 512'(out_valid[u]), 512'(0));
      check_w("rst_quotient", obs_q(u), '0);
      check_w("rst_remainder", obs_r(u), '0);
      check("rst_dbz", 512'(dbz[u]), 512'(0));
    end
    @(negedge clk);
    rst = 1'b0;

    // 8-bit directed cases.
    send(0, 100, 7);  receive(0, 0);
    send(0, 5, 0);    receive(0, 0);
    send(0, 255, 1);  receive(0, 0);
    send(0, 3, 200);  receive(0, 5);
    send(0, 7, 100);  receive(0, 0);
    send(0, 200, 200); receive(0, 0);
`ifdef NRDIV_SIGNED_EN
    send(0, 8'h9C, 7);    receive(0, 0);
    send(0, 100, 8'hF9);  receive(0, 0);
    send(0, 8'h80, 8'hFF); receive(0, 0);
`endif
    for (int i = 0; i < 8; i++) begin
      send(0, WL'($urandom_range(0, 255)), WL'($urandom_range(0, 255)));
      receive(0, 0);
    end

    // 1024-bit corner, then random back-to-back transfers.
    n = WL'(1) << (WL - 1);
    d = (WL'(1) << 512) + WL'(1);
    send(1, n, d);
    receive(1, 0);
    prev_acc = acc_cyc;
    for (int i = 0; i < 3; i++) begin
      n = rand_w();
      d = rand_w() >> $urandom_range(0, WL - 8);
      if (d == '0) d = WL'(3);
      send(1, n, d);
      check("throughput_cycles", 512'(acc_cyc - prev_acc), 512'(WL + 3 + EXTRA));
      prev_acc = acc_cyc;
      receive(1, 0);
    end

    // Abort a wide division mid-iteration with an asynchronous reset.
    send(1, rand_w(), rand_w() >> 300);
    repeat (300) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 512'(out_valid[1]), 512'(0));
    check("abort_in_ready", 512'(in_ready[1]), 512'(1));
    void'(sb_l.pop_front());
    @(negedge clk);
    rst = 1'b0;
    send(1, rand_w(), rand_w() >> 100);
    receive(1, 0);
    send(1, rand_w(), '0);
    receive(1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
